// File: rtl/mpu_mem_streamer.sv
// Memory-side initiator of the mem_load_* interface: host-preloaded local matrix memory,
// streamed row-major to mpu_load one element per ack, with done/error reporting.
module mpu_mem_streamer #(
  parameter int FP_WIDTH   = 32,
  parameter int MAX_DIM    = 3,
  parameter int DIM_BITS   = 2,
  parameter int REG_AWIDTH = 3,
  parameter int MEM_DEPTH  = 64,
  parameter int MEM_AWIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_start_in,
  input  logic [MEM_AWIDTH-1:0] cmd_base_in,
  input  logic [DIM_BITS-1:0]   cmd_m_in,
  input  logic [DIM_BITS-1:0]   cmd_n_in,
  input  logic [REG_AWIDTH-1:0] cmd_reg_addr_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  cmd_error_out,
  input  logic                  mem_wr_en_in,
  input  logic [MEM_AWIDTH-1:0] mem_wr_addr_in,
  input  logic [FP_WIDTH-1:0]   mem_wr_data_in,
  output logic                  load_req_out,
  output logic [REG_AWIDTH-1:0] mem_load_addr_out,
  output logic [DIM_BITS-1:0]   mem_m_load_size_out,
  output logic [DIM_BITS-1:0]   mem_n_load_size_out,
  output logic [FP_WIDTH-1:0]   mem_load_element_out,
  output logic                  mem_load_valid_out,
  input  logic                  mem_load_ack_in,
  input  logic                  mem_load_error_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_STREAM,
    S_DONE,
    S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [MEM_AWIDTH-1:0]   addr_q, addr_d;
  logic [DIM_BITS-1:0]     m_q, m_d;
  logic [DIM_BITS-1:0]     n_q, n_d;
  logic [DIM_BITS-1:0]     i_q, i_d;
  logic [DIM_BITS-1:0]     j_q, j_d;
  logic [REG_AWIDTH-1:0]   reg_addr_q, reg_addr_d;
  logic [FP_WIDTH-1:0]     elem_q;
  logic [FP_WIDTH-1:0]     mem_q [MEM_DEPTH];
  logic [MEM_AWIDTH-1:0]   rd_addr;
  logic                    dims_ok;
  logic                    last_col;
  logic                    last_elem;
  logic                    streaming;
  logic                    active;

  assign dims_ok = (cmd_m_in != '0) && (int'(cmd_m_in) <= MAX_DIM) &&
                   (cmd_n_in != '0) && (int'(cmd_n_in) <= MAX_DIM);

  assign last_col  = (j_q == n_q - DIM_BITS'(1));
  assign last_elem = last_col && (i_q == m_q - DIM_BITS'(1));

  // Row-major order makes the memory offset a plain +1 per element, so one
  // wrapping address counter replaces the i*N+j computation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    m_d        = m_q;
    n_d        = n_q;
    i_d        = i_q;
    j_d        = j_q;
    reg_addr_d = reg_addr_q;
    rd_addr    = addr_q;

    case (state_q)
      S_IDLE: begin
        rd_addr = cmd_base_in;
        if (cmd_start_in) begin
          if (dims_ok) begin
            state_d    = S_REQ;
            addr_d     = cmd_base_in;
            m_d        = cmd_m_in;
            n_d        = cmd_n_in;
            reg_addr_d = cmd_reg_addr_in;
            i_d        = '0;
            j_d        = '0;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_REQ: begin
        if (mem_load_error_in) begin
          state_d = S_ERR;
        end else begin
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        if (mem_load_error_in) begin
          state_d = S_ERR;
        end else if (mem_load_ack_in) begin
          if (last_elem) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + MEM_AWIDTH'(1);
            rd_addr = addr_q + MEM_AWIDTH'(1);
            if (last_col) begin
              j_d = '0;
              i_d = i_q + DIM_BITS'(1);
            end else begin
              j_d = j_q + DIM_BITS'(1);
            end
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      m_q        <= '0;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      reg_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      m_q        <= m_d;
      n_q        <= n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      reg_addr_q <= reg_addr_d;
    end
  end

  // Read and write share the edge, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (mem_wr_en_in) begin
      mem_q[mem_wr_addr_in] <= mem_wr_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elem_q <= '0;
    end else begin
      elem_q <= mem_q[rd_addr];
    end
  end

  assign streaming = (state_q == S_STREAM);
  assign active    = (state_q == S_REQ) || streaming;

  assign busy_out             = (state_q != S_IDLE);
  assign done_out             = (state_q == S_DONE);
  assign cmd_error_out        = (state_q == S_ERR);
  assign load_req_out         = (state_q == S_REQ);
  assign mem_load_valid_out   = streaming;
  assign mem_load_element_out = streaming ? elem_q : '0;
  assign mem_load_addr_out    = active ? reg_addr_q : '0;
  assign mem_m_load_size_out  = active ? m_q : '0;
  assign mem_n_load_size_out  = active ? n_q : '0;

endmodule

// File: tb/tb_mpu_mem_streamer.sv
// Directed bench for mpu_mem_streamer with hand-computed expected values.
module tb_mpu_mem_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start_in;
  logic [5:0]  cmd_base_in;
  logic [1:0]  cmd_m_in;
  logic [1:0]  cmd_n_in;
  logic [2:0]  cmd_reg_addr_in;
  logic        busy_out;
  logic        done_out;
  logic        cmd_error_out;
  logic        mem_wr_en_in;
  logic [5:0]  mem_wr_addr_in;
  logic [31:0] mem_wr_data_in;
  logic        load_req_out;
  logic [2:0]  mem_load_addr_out;
  logic [1:0]  mem_m_load_size_out;
  logic [1:0]  mem_n_load_size_out;
  logic [31:0] mem_load_element_out;
  logic        mem_load_valid_out;
  logic        mem_load_ack_in;
  logic        mem_load_error_in;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] fp_tbl [0:8];
  logic [31:0] wrap_tbl [0:3];

  always #5 clk = ~clk;

  mpu_mem_streamer dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd_start_in         (cmd_start_in),
    .cmd_base_in          (cmd_base_in),
    .cmd_m_in             (cmd_m_in),
    .cmd_n_in             (cmd_n_in),
    .cmd_reg_addr_in      (cmd_reg_addr_in),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .cmd_error_out        (cmd_error_out),
    .mem_wr_en_in         (mem_wr_en_in),
    .mem_wr_addr_in       (mem_wr_addr_in),
    .mem_wr_data_in       (mem_wr_data_in),
    .load_req_out         (load_req_out),
    .mem_load_addr_out    (mem_load_addr_out),
    .mem_m_load_size_out  (mem_m_load_size_out),
    .mem_n_load_size_out  (mem_n_load_size_out),
    .mem_load_element_out (mem_load_element_out),
    .mem_load_valid_out   (mem_load_valid_out),
    .mem_load_ack_in      (mem_load_ack_in),
    .mem_load_error_in    (mem_load_error_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [5:0] a, input logic [31:0] d);
    mem_wr_en_in   = 1'b1;
    mem_wr_addr_in = a;
    mem_wr_data_in = d;
    tick();
    mem_wr_en_in   = 1'b0;
  endtask

  task automatic start(input logic [5:0] base, input logic [1:0] m, input logic [1:0] n,
                       input logic [2:0] ra);
    cmd_start_in    = 1'b1;
    cmd_base_in     = base;
    cmd_m_in        = m;
    cmd_n_in        = n;
    cmd_reg_addr_in = ra;
    tick();
    cmd_start_in    = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy_out), 32'd0);
    check({tag, "_valid"}, 32'(mem_load_valid_out), 32'd0);
    check({tag, "_req"}, 32'(load_req_out), 32'd0);
    check({tag, "_done"}, 32'(done_out), 32'd0);
    check({tag, "_err"}, 32'(cmd_error_out), 32'd0);
    check({tag, "_elem"}, mem_load_element_out, 32'd0);
    check({tag, "_sizes"}, {27'd0, mem_load_addr_out, mem_m_load_size_out}, 32'd0);
    check({tag, "_nsize"}, 32'(mem_n_load_size_out), 32'd0);
  endtask

  initial begin
    fp_tbl[0] = 32'h3F800000; fp_tbl[1] = 32'h40000000; fp_tbl[2] = 32'h40400000;
    fp_tbl[3] = 32'h40800000; fp_tbl[4] = 32'h40A00000; fp_tbl[5] = 32'h40C00000;
    fp_tbl[6] = 32'h40E00000; fp_tbl[7] = 32'h41000000; fp_tbl[8] = 32'h41100000;
    wrap_tbl[0] = 32'hA0A0_0001; wrap_tbl[1] = 32'hB0B0_0002;
    wrap_tbl[2] = 32'hC0C0_0003; wrap_tbl[3] = 32'hD0D0_0004;

    rst = 1'b1; cmd_start_in = 1'b0; cmd_base_in = '0; cmd_m_in = '0; cmd_n_in = '0;
    cmd_reg_addr_in = '0; mem_wr_en_in = 1'b0; mem_wr_addr_in = '0; mem_wr_data_in = '0;
    mem_load_ack_in = 1'b0; mem_load_error_in = 1'b0;
    tick(); tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();
    check_quiet("idle");

    for (int k = 0; k < 9; k++) mem_write(6'(10 + k), fp_tbl[k]);
    mem_write(6'd62, wrap_tbl[0]);
    mem_write(6'd63, wrap_tbl[1]);
    mem_write(6'd0,  wrap_tbl[2]);
    mem_write(6'd1,  wrap_tbl[3]);

    // 3x3 from base 10 with ack held high
    mem_load_ack_in = 1'b1;
    start(6'd10, 2'd3, 2'd3, 3'd5);
    check("t1_req", 32'(load_req_out), 32'd1);
    check("t1_req_valid", 32'(mem_load_valid_out), 32'd0);
    check("t1_req_fields", {26'd0, mem_load_addr_out, mem_m_load_size_out, 1'b0},
          {26'd0, 3'd5, 2'd3, 1'b0});
    check("t1_req_n", 32'(mem_n_load_size_out), 32'd3);
    tick();
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t1_valid%0d", k), 32'(mem_load_valid_out), 32'd1);
      check($sformatf("t1_elem%0d", k), mem_load_element_out, fp_tbl[k]);
      check($sformatf("t1_nodone%0d", k), {31'd0, done_out | load_req_out}, 32'd0);
      tick();
    end
    check("t1_done", 32'(done_out), 32'd1);
    check("t1_done_valid", 32'(mem_load_valid_out), 32'd0);
    check("t1_done_size", 32'(mem_m_load_size_out), 32'd0);
    tick();
    check_quiet("t1_after");

    // 2x2 from base 62 wraps through address 0
    start(6'd62, 2'd2, 2'd2, 3'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_elem%0d", k), mem_load_element_out, wrap_tbl[k]);
      tick();
    end
    check("t2_done", 32'(done_out), 32'd1);
    tick();
    mem_load_ack_in = 1'b0;

    // Illegal dimensions
    start(6'd10, 2'd0, 2'd2, 3'd2);
    check("t3_err", 32'(cmd_error_out), 32'd1);
    check("t3_noreq", 32'(load_req_out), 32'd0);
    tick();
    check("t3_err_pulse", 32'(cmd_error_out), 32'd0);
    check("t3_idle", 32'(busy_out), 32'd0);
    check("t3_noreq2", 32'(load_req_out), 32'd0);

    // 2x2 with an ack every third cycle
    start(6'd10, 2'd2, 2'd2, 3'd3);
    tick();
    for (int c = 0; c < 12; c++) begin
      mem_load_ack_in = ((c % 3) == 2);
      check($sformatf("t4_valid%0d", c), 32'(mem_load_valid_out), 32'd1);
      check($sformatf("t4_elem%0d", c), mem_load_element_out, fp_tbl[c / 3]);
      check($sformatf("t4_nodone%0d", c), 32'(done_out), 32'd0);
      tick();
    end
    mem_load_ack_in = 1'b0;
    check("t4_done", 32'(done_out), 32'd1);
    tick();
    check("t4_done_once", 32'(done_out), 32'd0);
    check("t4_idle", 32'(busy_out), 32'd0);

    // Error together with the ack of element 1
    mem_load_ack_in = 1'b1;
    start(6'd10, 2'd3, 2'd3, 3'd4);
    tick();
    check("t5_elem0", mem_load_element_out, fp_tbl[0]);
    tick();
    check("t5_elem1", mem_load_element_out, fp_tbl[1]);
    mem_load_error_in = 1'b1;
    tick();
    mem_load_error_in = 1'b0;
    mem_load_ack_in = 1'b0;
    check("t5_err", 32'(cmd_error_out), 32'd1);
    check("t5_valid", 32'(mem_load_valid_out), 32'd0);
    check("t5_nodone", 32'(done_out), 32'd0);
    tick();
    check("t5_idle", 32'(busy_out), 32'd0);
    check("t5_nodone2", 32'(done_out), 32'd0);
    start(6'd12, 2'd1, 2'd1, 3'd6);
    check("t5_restart_req", 32'(load_req_out), 32'd1);
    tick();
    check("t5_restart_elem", mem_load_element_out, fp_tbl[2]);
    mem_load_ack_in = 1'b1;
    tick();
    mem_load_ack_in = 1'b0;
    check("t5_restart_done", 32'(done_out), 32'd1);
    tick();

    // Start ignored during STREAM, then reset mid-transfer
    start(6'd10, 2'd2, 2'd2, 3'd2);
    tick();
    check("t6_elem0", mem_load_element_out, fp_tbl[0]);
    cmd_start_in = 1'b1; cmd_base_in = 6'd14; cmd_m_in = 2'd1; cmd_n_in = 2'd1;
    mem_load_ack_in = 1'b1;
    tick();
    cmd_start_in = 1'b0;
    mem_load_ack_in = 1'b0;
    check("t6_still_valid", 32'(mem_load_valid_out), 32'd1);
    check("t6_elem1", mem_load_element_out, fp_tbl[1]);
    check("t6_msize", 32'(mem_m_load_size_out), 32'd2);
    check("t6_noreq", 32'(load_req_out), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("t6_rst");
    tick();
    check_quiet("t6_post");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
